// File: rtl/vector_writeback_stage.sv
// MEM/WB pipe register and write-back source select for the vector CPU.
// Drives the pixel and multiplier register-file write ports and counts committed instructions.
module vector_writeback_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               wr_pxl_in,
    input  logic               wr_pos_in,
    input  logic               wr_mul_reg_in,
    input  logic               wr_mul_pos_in,
    input  logic               wr_wom_in,
    input  logic [1:0]         src_sel,
    input  logic [DATA_W-1:0]  r1_in,
    input  logic [DATA_W-1:0]  r2_in,
    input  logic [DATA_W-1:0]  r3_in,
    input  logic [DATA_W-1:0]  r4_in,
    input  logic [DATA_W-1:0]  load1_in,
    input  logic [DATA_W-1:0]  load2_in,
    input  logic [DATA_W-1:0]  load3_in,
    input  logic [DATA_W-1:0]  load4_in,
    input  logic [DATA_W-1:0]  sumr1_in,
    input  logic [DATA_W-1:0]  sumr2_in,
    input  logic [DATA_W-1:0]  sumr3_in,
    input  logic [DATA_W-1:0]  sumr4_in,
    input  logic               mul_pair_en,
    output logic               we_pxl,
    output logic               wr_pos_pxl,
    output logic [DATA_W-1:0]  wdp1,
    output logic [DATA_W-1:0]  wdp2,
    output logic [DATA_W-1:0]  wdp3,
    output logic [DATA_W-1:0]  wdp4,
    output logic               we_mul,
    output logic               wr_mul_pos,
    output logic [DATA_W-1:0]  wdm1,
    output logic [DATA_W-1:0]  wdm2,
    output logic [DATA_W-1:0]  wdm3,
    output logic [DATA_W-1:0]  wdm4,
    output logic               mul_pair_done,
    output logic [COUNT_W-1:0] commit_cnt
);

    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } half_e;

    half_e               state_q, state_d;
    logic                we_pxl_q, we_pxl_d;
    logic                pos_pxl_q, pos_pxl_d;
    logic                we_mul_q, we_mul_d;
    logic                mul_pos_q, mul_pos_d;
    logic                done_q, done_d;
    logic [COUNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]   lane_q [4];
    logic [DATA_W-1:0]   lane_d [4];
    logic [DATA_W-1:0]   sel_lane [4];
    logic                capture;

    assign capture = !flush && !stall;

    always_comb begin
        case (src_sel)
            2'd1:    sel_lane = '{load1_in, load2_in, load3_in, load4_in};
            2'd2:    sel_lane = '{sumr1_in, sumr2_in, sumr3_in, sumr4_in};
            default: sel_lane = '{r1_in, r2_in, r3_in, r4_in};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HALF_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving pair mode or flushing always abandons a pending high half.
    always_comb begin
        state_d = state_q;
        if (!mul_pair_en || flush) begin
            state_d = HALF_LO;
        end else if (!stall && wr_mul_reg_in) begin
            state_d = (state_q == HALF_LO) ? HALF_HI : HALF_LO;
        end
    end

    always_comb begin
        we_pxl_d  = 1'b0;
        we_mul_d  = 1'b0;
        done_d    = 1'b0;
        pos_pxl_d = pos_pxl_q;
        mul_pos_d = mul_pos_q;
        cnt_d     = cnt_q;
        lane_d    = lane_q;
        if (capture) begin
            we_pxl_d  = wr_pxl_in;
            pos_pxl_d = wr_pos_in;
            we_mul_d  = wr_mul_reg_in;
            lane_d    = sel_lane;
            if (wr_pxl_in || wr_mul_reg_in || wr_wom_in) begin
                cnt_d = cnt_q + COUNT_W'(1);
            end
            if (!mul_pair_en) begin
                mul_pos_d = wr_mul_pos_in;
            end else if (wr_mul_reg_in) begin
                if (state_q == HALF_LO) begin
                    mul_pos_d = 1'b0;
                end else begin
                    mul_pos_d = 1'b1;
                    done_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_pxl_q  <= 1'b0;
            pos_pxl_q <= 1'b0;
            we_mul_q  <= 1'b0;
            mul_pos_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            we_pxl_q  <= we_pxl_d;
            pos_pxl_q <= pos_pxl_d;
            we_mul_q  <= we_mul_d;
            mul_pos_q <= mul_pos_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            for (int unsigned i = 0; i < 4; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    assign we_pxl        = we_pxl_q;
    assign wr_pos_pxl    = pos_pxl_q;
    assign we_mul        = we_mul_q;
    assign wr_mul_pos    = mul_pos_q;
    assign mul_pair_done = done_q;
    assign commit_cnt    = cnt_q;
    assign wdp1          = lane_q[0];
    assign wdp2          = lane_q[1];
    assign wdp3          = lane_q[2];
    assign wdp4          = lane_q[3];
    assign wdm1          = lane_q[0];
    assign wdm2          = lane_q[1];
    assign wdm3          = lane_q[2];
    assign wdm4          = lane_q[3];

endmodule

// File: doc/vector_writeback_stage.md
Name: vector_writeback_stage

Overview:
- Final (WB) stage of the vector CPU pipeline. Sits directly downstream of the memory stage and its EXE/MEM pipe register.
- Registers MEM-stage results (MEM/WB boundary) and selects the write-back source: ALU lanes r1..r4, load lanes or sum lanes.
- Drives the pixel and multiplier register-file write ports back into Decode.
- Includes a two-half sequencer that fills the 8-word multiplier file from consecutive 4-lane results, plus a commit counter for debug and performance.

Parameters:
DATA_W, 32, lane width in bits
COUNT_W, 16, width of commit counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
stall  in  1  hold stage, suppress writes
flush  in  1  discard the instruction being captured
wr_pxl_in  in  1  pixel-file write request from MEM pipe
wr_pos_in  in  1  pixel write position from MEM pipe
wr_mul_reg_in  in  1  mul-file write request from MEM pipe
wr_mul_pos_in  in  1  mul half select (low=0, high=1) when pairing is off
wr_wom_in  in  1  WOM store flag, counted only
src_sel  in  2  data source: 0 = r lanes, 1 = load lanes, 2 = sumr lanes, 3 = r lanes
r1_in..r4_in  in  DATA_W each  ALU result lanes
load1_in..load4_in  in  DATA_W each  memory load lanes
sumr1_in..sumr4_in  in  DATA_W each  accumulated sum lanes
mul_pair_en  in  1  automatic low/high mul-half sequencing
we_pxl  out  1  pixel-file write enable
wr_pos_pxl  out  1  pixel-file write position
wdp1..wdp4  out  DATA_W each  pixel write data
we_mul  out  1  mul-file write enable
wr_mul_pos  out  1  mul-file half select
wdm1..wdm4  out  DATA_W each  mul write data
mul_pair_done  out  1  one-cycle pulse alongside a high-half write in pair mode
commit_cnt  out  COUNT_W  count of committed instructions

Behaviour:
- Reset (rst=0, async): all outputs 0, including we_pxl, we_mul, wr_pos_pxl, wr_mul_pos, wdp*, wdm*, mul_pair_done and commit_cnt. Sequencer goes to HALF_LO. Reset mid-sequence abandons the pending half; no write issues.
- Latency: inputs sampled at edge N appear on write ports after edge N and are valid for exactly one cycle. All outputs are registered; there is no combinational input-to-output path.
- Data mux, applied before the register: lane k = r_k, load_k or sumr_k per src_sel. src_sel=3 is treated as 0. The same selected lanes go to both wdp and wdm.
- Capture at each edge with precedence flush > stall > normal:
  - flush=1: we_pxl, we_mul and mul_pair_done go to 0; sequencer goes to HALF_LO; no count.
  - stall=1: data/position registers hold; we_pxl, we_mul and mul_pair_done go to 0; sequencer and counter hold. Upstream holds its outputs, so the same instruction is recaptured once stall drops.
  - normal: we_pxl <= wr_pxl_in, wr_pos_pxl <= wr_pos_in, we_mul <= wr_mul_reg_in, data registers load.
- Mul sequencer, states HALF_LO and HALF_HI:
  - mul_pair_en=0: wr_mul_pos <= wr_mul_pos_in; state forced to HALF_LO; mul_pair_done=0.
  - mul_pair_en=1 with a normal capture where wr_mul_reg_in=1:
    - From HALF_LO: wr_mul_pos <= 0, next state HALF_HI.
    - From HALF_HI: wr_mul_pos <= 1, mul_pair_done <= 1, next state HALF_LO.
  - Captures without wr_mul_reg_in leave the state unchanged.
  - If mul_pair_en drops while in HALF_HI, the state returns to HALF_LO at the next edge.
- Pixel and mul writes in the same cycle are independent and both issue.
- commit_cnt increments by 1 on each normal capture where (wr_pxl_in | wr_mul_reg_in | wr_wom_in) = 1. It wraps from 2^COUNT_W-1 to 0. A wr_wom_in-only instruction asserts no write enable but is still counted.

Test Plan:
- Reset release, then wr_pxl_in=1, wr_pos_in=1, src_sel=0, r=1,2,3,4 at edge N -> after N: we_pxl=1, wr_pos_pxl=1, wdp=1,2,3,4. After N+1: we_pxl=0. commit_cnt=1.
- src_sel=1 with load=0xA..0xD, then src_sel=2 with sumr=0x10..0x13, then src_sel=3 -> wdp follows load, then sumr, then the r lanes, one cycle each.
- mul_pair_en=1, three consecutive wr_mul_reg_in=1 captures -> wr_mul_pos = 0, 1, 0 and mul_pair_done = 0, 1, 0.
- Two-cycle stall during an active pixel write stream -> no we_pxl during the stall, wdp held, commit_cnt unchanged. The recaptured instruction writes exactly once.
- flush=1 together with stall=1 and wr_mul_reg_in=1 while sequencer is in HALF_HI -> we_mul=0, sequencer in HALF_LO. The next pair write issues wr_mul_pos=0.
- Preload commit_cnt to 0xFFFF via 65535 wr_wom_in-only captures, then one more -> commit_cnt=0x0000, no write enables. Asserting rst=0 mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
